cond_test_unit: RTL and testbench
=================================

COND_TEST_UNIT -- requirements
Module: cond_test_unit

Interface
REQ-001 Parameter WORD_LENGTH, default 20, bits per serial word; SHALL be >= 2.
REQ-002 Parameter FUNCTION_BITS, default 6, width of the function field.
REQ-003 Parameters FN_SKIP_NEG / FN_SKIP_ZERO / FN_SKIP_NONZERO / FN_SKIP_ALWAYS, defaults 6'h0C / 6'h0D / 6'h0E / 6'h0F, test function codes.
REQ-004 Port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst_n, input, 1, asynchronous active-low reset.
REQ-006 Port start, input, 1, request a test; sampled only in IDLE.
REQ-007 Port func, input, FUNCTION_BITS, function code; latched when start is accepted.
REQ-008 Port ser_bit, input, 1, accumulator word bit, LSB first.
REQ-009 Port ser_valid, input, 1, ser_bit valid this cycle.
REQ-010 Port busy, output, 1, high from the cycle after start acceptance until done.
REQ-011 Port beat, output, $clog2(WORD_LENGTH), index of the next bit to be accepted.
REQ-012 Port done, output, 1, one-cycle completion pulse.
REQ-013 Port result, output, 1, test outcome; held until the next accepted start.
REQ-014 Port action_trigger, output, 1, one-cycle pulse coincident with done when result is 1 (skip/CI-increment request).

Function
REQ-015 FSM states SHALL be IDLE, SHIFT and DECIDE.
REQ-016 IDLE: start=1 SHALL latch func, clear the zero-accumulator, clear beat to 0, clear result, and enter SHIFT next cycle.
REQ-017 ser_valid in IDLE, including the start cycle, SHALL be ignored.
REQ-018 SHIFT: each cycle with ser_valid=1 SHALL OR ser_bit into the zero-accumulator and increment beat; cycles with ser_valid=0 SHALL stall with no state change.
REQ-019 When the bit accepted carries beat=WORD_LENGTH-1, it SHALL be captured as the sign bit, and the FSM SHALL enter DECIDE with beat wrapping to 0.
REQ-020 DECIDE SHALL last exactly one cycle: assert done, update result, pulse action_trigger when result=1, deassert busy, and return to IDLE.
REQ-021 Latency: done SHALL be high in the cycle after the last bit is accepted; a gap-free word SHALL complete WORD_LENGTH+2 cycles after start.
REQ-022 Result for FN_SKIP_NEG SHALL equal the sign bit.
REQ-023 Result for FN_SKIP_ZERO SHALL equal NOT(zero-accumulator).
REQ-024 Result for FN_SKIP_NONZERO SHALL equal the zero-accumulator.
REQ-025 Result for FN_SKIP_ALWAYS SHALL be 1.
REQ-026 Any other func SHALL still consume a full word to keep serial framing, and SHALL yield result=0.
REQ-027 start while busy or in DECIDE SHALL be ignored and SHALL NOT alter the latched func.
REQ-028 A start in the cycle after DECIDE, i.e. in IDLE, SHALL be accepted; back-to-back tests SHALL need no dead cycle beyond DECIDE.
REQ-029 func changes after acceptance SHALL have no effect on the running test.

Reset
REQ-030 rst_n=0 SHALL asynchronously force state IDLE, beat=0, busy=0, done=0, result=0, action_trigger=0, clear the accumulators and latched func.
REQ-031 Reset during SHIFT or DECIDE SHALL abort the test with no done or action_trigger pulse; the first start after release SHALL behave as from power-up.

Structure
REQ-032 The shared package SHALL hold the FSM state encoding, the FN_* function codes and the default WORD_LENGTH/FUNCTION_BITS constants, for reuse by the data-flow control unit.
REQ-033 The beat counter, with its increment/wrap/terminal flag, SHALL be one sub-module, beat_counter, parametrised by WORD_LENGTH.

Verification
REQ-034 The bench SHALL run all scenarios at WORD_LENGTH=20.
REQ-035 FN_SKIP_NEG, word 20'h80000 gap-free: done at cycle 22 after start, result=1, action_trigger=1.
REQ-036 FN_SKIP_ZERO, word 20'h00000: result=1. Repeating with 20'h00001: result=0 and no action_trigger.
REQ-037 FN_SKIP_NONZERO, word 20'h00400 with ser_valid low for 3 cycles at beat 5: done at cycle 25, result=1, beat back to 0.
REQ-038 func=6'h01, word 20'hFFFFF: done pulses, result=0; a start during SHIFT is ignored and busy stays high.
REQ-039 FN_SKIP_ALWAYS, rst_n pulsed low at beat 10: all outputs 0 immediately, no done. A new FN_SKIP_NEG test on 20'h7FFFF then gives result=0.
REQ-040 Back-to-back FN_SKIP_ALWAYS tests, start reasserted the cycle after done: two done pulses exactly 22 cycles apart.

Source files
------------

// File: rtl/cond_test_unit_pkg.sv
// Shared constants for the conditional-test unit and the data-flow control unit.
// Latency: n/a (types, codes and default sizes only).
// Backpressure: n/a.
package cond_test_unit_pkg;

    localparam int CTU_WORD_LENGTH   = 20;
    localparam int CTU_FUNCTION_BITS = 6;

    // Test function codes understood by the conditional-test unit
    localparam logic [5:0] CTU_FN_SKIP_NEG     = 6'h0C;
    localparam logic [5:0] CTU_FN_SKIP_ZERO    = 6'h0D;
    localparam logic [5:0] CTU_FN_SKIP_NONZERO = 6'h0E;
    localparam logic [5:0] CTU_FN_SKIP_ALWAYS  = 6'h0F;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_DECIDE = 2'd2
    } ctu_state_t;

endpackage

// File: rtl/cond_test_unit_if.sv
// Request / serial-word / completion bundle of the conditional-test unit.
// Latency: n/a (wiring only).
// Backpressure: ser_valid low stalls the serial word; start is ignored while busy.
interface cond_test_unit_if
    import cond_test_unit_pkg::*;
#(
    parameter int WORD_LENGTH   = CTU_WORD_LENGTH,
    parameter int FUNCTION_BITS = CTU_FUNCTION_BITS
);
    logic                           start;
    logic [FUNCTION_BITS-1:0]       func;
    logic                           ser_bit;
    logic                           ser_valid;
    logic                           busy;
    logic [$clog2(WORD_LENGTH)-1:0] beat;
    logic                           done;
    logic                           result;
    logic                           action_trigger;

    modport master (
        output start, func, ser_bit, ser_valid,
        input  busy, beat, done, result, action_trigger
    );

    modport slave (
        input  start, func, ser_bit, ser_valid,
        output busy, beat, done, result, action_trigger
    );
endinterface

// File: rtl/cond_test_unit_beat_counter.sv
// Serial bit-position counter: clears, increments, wraps at WORD_LENGTH-1.
// Latency: beat updates one cycle after clr/inc; last is combinational on beat.
// Backpressure: holds its value whenever inc is low.
module beat_counter
    import cond_test_unit_pkg::*;
#(
    parameter int WORD_LENGTH = CTU_WORD_LENGTH
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clr,
    input  logic                           inc,
    output logic [$clog2(WORD_LENGTH)-1:0] beat,
    output logic                           last
);
    localparam int BW = $clog2(WORD_LENGTH);
    localparam logic [BW-1:0] LAST_BEAT = BW'(WORD_LENGTH - 1);

    logic [BW-1:0] beat_q;
    logic [BW-1:0] beat_d;

    assign last = (beat_q == LAST_BEAT);
    assign beat = beat_q;

    // Next beat: clear wins, otherwise advance and wrap after the final bit
    always_comb begin
        beat_d = beat_q;
        if (clr) begin
            beat_d = '0;
        end else if (inc) begin
            beat_d = last ? '0 : beat_q + BW'(1);
        end
    end

    // Beat register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q <= '0;
        end else begin
            beat_q <= beat_d;
        end
    end
endmodule

// File: rtl/cond_test_unit.sv
// Conditional skip test on a serial LSB-first accumulator word (sign / zero tests).
// Latency: done one cycle after the last bit; WORD_LENGTH+2 cycles from start when gap-free.
// Backpressure: ser_valid low stalls the shift; start is ignored outside IDLE.
module cond_test_unit
    import cond_test_unit_pkg::*;
#(
    parameter int                       WORD_LENGTH     = CTU_WORD_LENGTH,
    parameter int                       FUNCTION_BITS   = CTU_FUNCTION_BITS,
    parameter logic [FUNCTION_BITS-1:0] FN_SKIP_NEG     = FUNCTION_BITS'(CTU_FN_SKIP_NEG),
    parameter logic [FUNCTION_BITS-1:0] FN_SKIP_ZERO    = FUNCTION_BITS'(CTU_FN_SKIP_ZERO),
    parameter logic [FUNCTION_BITS-1:0] FN_SKIP_NONZERO = FUNCTION_BITS'(CTU_FN_SKIP_NONZERO),
    parameter logic [FUNCTION_BITS-1:0] FN_SKIP_ALWAYS  = FUNCTION_BITS'(CTU_FN_SKIP_ALWAYS)
) (
    input  logic              clk,
    input  logic              rst_n,
    cond_test_unit_if.slave   bus
);
    ctu_state_t               state_q, state_d;
    logic [FUNCTION_BITS-1:0] func_q, func_d;
    logic                     nz_acc_q, nz_acc_d;   // 1 once any accepted bit was 1
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     result_q, result_d;
    logic                     action_q, action_d;

    logic                     cnt_clr;
    logic                     cnt_inc;
    logic                     cnt_last;
    logic                     nz_word;
    logic                     outcome;

    beat_counter #(
        .WORD_LENGTH (WORD_LENGTH)
    ) u_beat_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .beat  (bus.beat),
        .last  (cnt_last)
    );

    // Test outcome as it would be if the current serial bit is the sign bit
    always_comb begin
        nz_word = nz_acc_q | bus.ser_bit;
        outcome = 1'b0;
        if (func_q == FN_SKIP_NEG) begin
            outcome = bus.ser_bit;
        end else if (func_q == FN_SKIP_ZERO) begin
            outcome = ~nz_word;
        end else if (func_q == FN_SKIP_NONZERO) begin
            outcome = nz_word;
        end else if (func_q == FN_SKIP_ALWAYS) begin
            outcome = 1'b1;
        end
    end

    // FSM next state; done/result/action are set on the edge entering DECIDE
    // so that they are registered and valid for exactly the DECIDE cycle
    always_comb begin
        state_d  = state_q;
        func_d   = func_q;
        nz_acc_d = nz_acc_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        action_d = 1'b0;
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    func_d   = bus.func;
                    nz_acc_d = 1'b0;
                    result_d = 1'b0;
                    busy_d   = 1'b1;
                    cnt_clr  = 1'b1;
                    state_d  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bus.ser_valid) begin
                    cnt_inc  = 1'b1;
                    nz_acc_d = nz_word;
                    if (cnt_last) begin
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        result_d = outcome;
                        action_d = outcome;
                        state_d  = ST_DECIDE;
                    end
                end
            end
            ST_DECIDE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            func_q   <= '0;
            nz_acc_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= 1'b0;
            action_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            func_q   <= func_d;
            nz_acc_q <= nz_acc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            action_q <= action_d;
        end
    end

    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.result         = result_q;
    assign bus.action_trigger = action_q;
endmodule

// File: tb/tb_cond_test_unit.sv
// Bench for cond_test_unit: directed scenarios plus randomized tests against a word-level model.
// Latency: checks done at WORD_LENGTH+2 plus stall cycles after start.
// Backpressure: exercises ser_valid stalls and ignored starts.
module tb_cond_test_unit;
    import cond_test_unit_pkg::*;

    localparam int WL = 20;
    localparam int FB = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cond_test_unit_if #(.WORD_LENGTH(WL), .FUNCTION_BITS(FB)) ifc ();

    cond_test_unit #(.WORD_LENGTH(WL), .FUNCTION_BITS(FB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Word-level reference: decide the skip from the whole 20-bit value
    function automatic logic model(input logic [5:0] f, input logic [19:0] w);
        case (f)
            CTU_FN_SKIP_NEG:     return ((w >> 19) & 20'd1) != 0;
            CTU_FN_SKIP_ZERO:    return w == 20'd0;
            CTU_FN_SKIP_NONZERO: return w != 20'd0;
            CTU_FN_SKIP_ALWAYS:  return 1'b1;
            default:             return 1'b0;
        endcase
    endfunction

    // One full test. Caller is #1 after an edge with the DUT in IDLE.
    // Returns #1 after the edge following the done cycle (DUT back in IDLE).
    task automatic run_test(input logic [5:0] f, input logic [19:0] w,
                            input int stall_at, input int stall_len,
                            input int inj_at, input bit scramble,
                            output int done_at);
        int   n, idx, stalls;
        bit   seen, inj_pending;
        logic exp;
        exp = model(f, w);
        ifc.start     = 1'b1;
        ifc.func      = f;
        ifc.ser_valid = 1'($urandom);
        ifc.ser_bit   = 1'($urandom);
        @(posedge clk); #1;
        ifc.start = 1'b0;
        chk("busy_after_start", ifc.busy, 1);
        chk("result_cleared", ifc.result, 0);
        n = 2; idx = 0; stalls = 0; seen = 0; inj_pending = 0; done_at = -1;
        while (n < 200) begin
            if (ifc.done === 1'b1) begin
                seen = 1;
                break;
            end
            if (scramble) ifc.func = 6'($urandom);
            if (idx == inj_at && !inj_pending) begin
                ifc.start   = 1'b1;
                ifc.func    = CTU_FN_SKIP_ALWAYS;
                inj_pending = 1;
            end else begin
                ifc.start = 1'b0;
            end
            if (idx == stall_at && stalls < stall_len) begin
                if (stalls == 0) chk("beat_at_stall", ifc.beat, stall_at);
                ifc.ser_valid = 1'b0;
                ifc.ser_bit   = 1'($urandom);
                stalls++;
            end else if (idx < WL) begin
                ifc.ser_valid = 1'b1;
                ifc.ser_bit   = w[idx];
                idx++;
            end else begin
                ifc.ser_valid = 1'b0;
            end
            @(posedge clk); #1;
            n++;
            if (ifc.start) chk("busy_after_ignored_start", ifc.busy, 1);
        end
        ifc.start     = 1'b0;
        ifc.ser_valid = 1'b0;
        chk("done_seen", 32'(seen), 1);
        chk("latency", n, 22 + stall_len);
        chk("result", ifc.result, 32'(exp));
        chk("action", ifc.action_trigger, 32'(exp));
        chk("busy_at_done", ifc.busy, 0);
        chk("beat_wrap", ifc.beat, 0);
        done_at = cyc;
        @(posedge clk); #1;
        chk("done_one_cycle", ifc.done, 0);
        chk("action_one_cycle", ifc.action_trigger, 0);
        chk("result_held", ifc.result, 32'(exp));
    endtask

    initial begin
        int d1, d2, dn, an, kind;
        logic [5:0]  f;
        logic [19:0] w;
        ifc.start = 1'b0; ifc.func = '0; ifc.ser_bit = 1'b0; ifc.ser_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", ifc.busy, 0);
        chk("rst_beat", ifc.beat, 0);
        chk("rst_done", ifc.done, 0);
        chk("rst_result", ifc.result, 0);
        chk("rst_action", ifc.action_trigger, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Sign test, gap-free
        run_test(CTU_FN_SKIP_NEG, 20'h80000, -1, 0, -1, 1'b0, d1);
        // Zero test on zero and on LSB-only word
        run_test(CTU_FN_SKIP_ZERO, 20'h00000, -1, 0, -1, 1'b0, d1);
        run_test(CTU_FN_SKIP_ZERO, 20'h00001, -1, 0, -1, 1'b0, d1);
        // Non-zero test with a 3-cycle stall at beat 5
        run_test(CTU_FN_SKIP_NONZERO, 20'h00400, 5, 3, -1, 1'b0, d1);
        // Unknown function with a start injected mid-word
        run_test(6'h01, 20'hFFFFF, -1, 0, 8, 1'b0, d1);

        // Reset in the middle of a test
        ifc.start = 1'b1; ifc.func = CTU_FN_SKIP_ALWAYS;
        @(posedge clk); #1;
        ifc.start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            ifc.ser_valid = 1'b1;
            ifc.ser_bit   = 1'($urandom);
            @(posedge clk); #1;
        end
        chk("beat_before_reset", ifc.beat, 10);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", ifc.busy, 0);
        chk("arst_beat", ifc.beat, 0);
        chk("arst_done", ifc.done, 0);
        chk("arst_result", ifc.result, 0);
        chk("arst_action", ifc.action_trigger, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        dn = 0; an = 0;
        for (int i = 0; i < 25; i++) begin
            ifc.ser_valid = 1'($urandom);
            ifc.ser_bit   = 1'($urandom);
            @(posedge clk); #1;
            if (ifc.done) dn++;
            if (ifc.action_trigger) an++;
        end
        ifc.ser_valid = 1'b0;
        chk("no_done_after_reset", dn, 0);
        chk("no_action_after_reset", an, 0);
        run_test(CTU_FN_SKIP_NEG, 20'h7FFFF, -1, 0, -1, 1'b0, d1);

        // Back-to-back tests
        run_test(CTU_FN_SKIP_ALWAYS, 20'($urandom), -1, 0, -1, 1'b0, d1);
        run_test(CTU_FN_SKIP_ALWAYS, 20'($urandom), -1, 0, -1, 1'b0, d2);
        chk("back_to_back_gap", d2 - d1, 22);

        // Randomized tests with func scrambled after acceptance
        for (int t = 0; t < 24; t++) begin
            kind = $urandom_range(0, 4);
            case (kind)
                0: f = CTU_FN_SKIP_NEG;
                1: f = CTU_FN_SKIP_ZERO;
                2: f = CTU_FN_SKIP_NONZERO;
                3: f = CTU_FN_SKIP_ALWAYS;
                default: begin
                    f = 6'($urandom);
                    while (f >= 6'h0C && f <= 6'h0F) f = 6'($urandom);
                end
            endcase
            case ($urandom_range(0, 2))
                0: w = 20'h00000;
                1: w = 20'h00001 << $urandom_range(0, 19);
                default: w = 20'($urandom);
            endcase
            run_test(f, w, $urandom_range(0, WL - 1), $urandom_range(0, 3), -1, 1'b1, d1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
